rr_stream_mux: RTL and testbench
================================

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL define SW = max(1, clog2(NCH)) as the select/grant width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mode  input  1  0 = fixed select via sel; 1 = round-robin.
REQ-007 SHALL have port sel  input  SW  channel index used when mode=0.
REQ-008 SHALL have port in_data  input  NCH*W  channel i occupies bits [i*W +: W].
REQ-009 SHALL have port in_valid  input  NCH  per-channel beat valid.
REQ-010 SHALL have port in_last  input  NCH  per-channel end-of-packet flag.
REQ-011 SHALL have port in_ready  output  NCH  per-channel accept; at most one bit high.
REQ-012 SHALL have port out_data  output  W  registered output beat.
REQ-013 SHALL have port out_valid  output  1  output beat valid.
REQ-014 SHALL have port out_last  output  1  registered copy of accepted in_last.
REQ-015 SHALL have port out_ready  input  1  downstream accept.
REQ-016 SHALL have port grant  output  SW  channel currently owning the output (registered).
REQ-017 SHALL have port busy  output  1  high while a packet is locked (state LOCKED).

Function
REQ-018 SHALL transfer a beat on channel i when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-019 SHALL hold a one-entry output register; slot_free = !out_valid || out_ready.
REQ-020 SHALL implement FSM states IDLE and LOCKED.
REQ-021 In IDLE, mode=0: candidate = sel; no candidate when sel >= NCH or !in_valid[sel].
REQ-022 In IDLE, mode=1: candidate = first i with in_valid[i], searched from (grant+1) mod NCH upward with wrap to 0.
REQ-023 In LOCKED: candidate = grant only; mode and sel changes SHALL be ignored until IDLE.
REQ-024 SHALL drive in_ready[candidate] = slot_free combinationally; all other in_ready bits 0; in_ready SHALL NOT depend on in_valid of the candidate in LOCKED.
REQ-025 On an input transfer: out_data/out_last load the beat next edge, out_valid=1, grant=candidate.
REQ-026 On an input transfer with in_last=0: next state LOCKED; with in_last=1: next state IDLE.
REQ-027 With out_ready=1 and no input transfer: out_valid clears next edge.
REQ-028 Latency: input beat to out_valid = 1 cycle; sustained throughput 1 beat/cycle while out_ready=1.
REQ-029 out_data, out_last, out_valid SHALL remain stable while out_valid && !out_ready.
REQ-030 Round-robin wrap: after grant=NCH-1, search starts at channel 0.
REQ-031 A sole requesting channel SHALL be granted every packet (no forced idle cycle).
REQ-032 No requester in IDLE: in_ready all 0, grant unchanged, state IDLE.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, out_valid=0, out_last=0, out_data=0, grant=NCH-1, busy=0.
REQ-034 Reset mid-packet SHALL discard the packet lock and the held beat; after release channel 0 has highest round-robin priority.

Verification
REQ-035 Fixed mode: NCH=4, W=8, mode=0, sel=2, ch2 sends 0xA5 last=1, out_ready=1 -> out_data=0xA5, out_last=1, grant=2 one cycle later; in_ready=4'b0100.
REQ-036 Round-robin: all four channels valid with single-beat packets, out_ready=1 -> grants 0,1,2,3,0 on consecutive beats.
REQ-037 Packet lock: ch1 sends 3-beat packet (0x11,0x12,0x13 last on third), ch0 and ch3 valid throughout -> three ch1 beats contiguous, busy=1 during beats 1-2, next grant=3.
REQ-038 Backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=0x3C -> out_data stays 0x3C, in_ready all 0; release -> 0x3C consumed, next beat follows next cycle.
REQ-039 Mode change mid-packet: mode 1->0, sel=3 while locked on ch2 -> ch2 packet completes, then grant=3.
REQ-040 Reset mid-packet: rst_n low during beat 2 of ch2 packet -> out_valid=0 immediately, busy=0; after release with all valid, first grant=0.

Source files
------------

// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_stream_mux
// Description : Packet-aware stream multiplexer. Selects one of NCH input
//               streams, either by a fixed index (mode=0) or round-robin
//               (mode=1), and forwards its beats through a one-entry output
//               register. Once the first beat of a multi-beat packet is
//               accepted, the channel stays locked until its last beat.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               mode, sel           - arbitration mode / fixed channel index
//               in_data/valid/last  - packed per-channel input streams
//               in_ready            - per-channel accept (one-hot or zero)
//               out_data/valid/last - registered output beat
//               out_ready           - downstream accept
//               grant               - channel currently owning the output
//               busy                - a packet is locked
// Revision    : 1.0 - initial release
// ============================================================================
module rr_stream_mux #(
    parameter  int NCH = 4,
    parameter  int W   = 8,
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH-1:0]   in_last,
    output logic [NCH-1:0]   in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [SW-1:0]    grant,
    output logic             busy
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [SW-1:0] r_grant;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_slot_free;
    logic          w_has;
    logic [SW-1:0] w_cand;
    logic [W-1:0]  w_beat;
    logic          w_beat_last;
    logic          w_cand_valid;
    logic          w_xfer;

    assign w_slot_free = !r_out_valid || out_ready;

    // Candidate selection. While locked, the owner is the only candidate and
    // is offered ready regardless of its valid, so a stalled packet keeps
    // its claim on the output.
    always_comb begin
        w_has  = 1'b0;
        w_cand = r_grant;
        if (r_state == S_LOCKED) begin
            w_has = 1'b1;
        end else if (!mode) begin
            // An out-of-range sel matches no channel and yields no candidate.
            for (int i = 0; i < NCH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_has  = 1'b1;
                    w_cand = SW'(i);
                end
            end
        end else begin
            // Search starts just after the last owner and wraps, so the
            // previous owner has the lowest priority on the next packet.
            for (int k = 1; k <= NCH; k++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!w_has && in_valid[i] &&
                        (((int'(r_grant) + k) % NCH) == i)) begin
                        w_has  = 1'b1;
                        w_cand = SW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        w_beat       = '0;
        w_beat_last  = 1'b0;
        w_cand_valid = 1'b0;
        in_ready     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_cand == SW'(i)) begin
                w_beat       = in_data[i*W +: W];
                w_beat_last  = in_last[i];
                w_cand_valid = in_valid[i];
                in_ready[i]  = w_has && w_slot_free;
            end
        end
    end

    assign w_xfer = w_has && w_slot_free && w_cand_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= SW'(NCH - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_beat;
            r_out_last  <= w_beat_last;
            r_out_valid <= 1'b1;
            r_grant     <= w_cand;
            r_state     <= w_beat_last ? S_IDLE : S_LOCKED;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign grant     = r_grant;
    assign busy      = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_stream_mux
// Description : Self-checking bench for rr_stream_mux. A behavioural model
//               tracks lock/owner/output-register contents; directed
//               scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_stream_mux;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int SW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic [SW-1:0]    sel;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_last;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [SW-1:0]    grant;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit          m_locked;
    int          m_grant;
    bit          m_ov;
    bit          m_ol;
    logic [W-1:0] m_od;

    always #5 clk = ~clk;

    rr_stream_mux #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_grant  = NCH - 1;
        m_ov     = 1'b0;
        m_ol     = 1'b0;
        m_od     = '0;
    endtask

    // Which channel may move a beat this cycle, or -1 for none.
    function automatic int model_cand();
        int c;
        int s;
        c = -1;
        if (m_locked) begin
            c = m_grant;
        end else if (mode == 1'b0) begin
            s = int'(sel);
            if (s < NCH && in_valid[s]) c = s;
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                s = (m_grant + k) % NCH;
                if (c < 0 && in_valid[s]) c = s;
            end
        end
        return c;
    endfunction

    // Called at posedge+1 with inputs already set: checks mid-cycle, then
    // advances the model across the next rising edge.
    task automatic step();
        int               cand;
        bit               slot_free;
        bit               xfer;
        logic [NCH-1:0]   exp_ready;
        #3;
        slot_free = !m_ov || out_ready;
        cand      = model_cand();
        exp_ready = '0;
        if (cand >= 0 && slot_free) exp_ready[cand] = 1'b1;
        xfer = (cand >= 0) && slot_free && in_valid[(cand < 0) ? 0 : cand];
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data",  32'(out_data),  32'(m_od));
        check("out_last",  32'(out_last),  32'(m_ol));
        check("grant",     32'(grant),     32'(m_grant));
        check("busy",      32'(busy),      32'(m_locked));
        @(posedge clk);
        if (xfer) begin
            m_ov     = 1'b1;
            m_od     = in_data[cand*W +: W];
            m_ol     = in_last[cand];
            m_grant  = cand;
            m_locked = !in_last[cand];
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    // Asserts reset between edges and checks its immediate effect.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant",     32'(grant),     32'(NCH - 1));
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] d, input logic l);
        in_data[ch*W +: W] = d;
        in_last[ch]        = l;
    endtask

    initial begin
        rst_n     = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        do_reset();
        step();

        // Fixed select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5, 1'b1);
        step();
        in_valid = '0;
        check("fix_data",  32'(out_data), 32'hA5);
        check("fix_last",  32'(out_last), 32'd1);
        check("fix_grant", 32'(grant),    32'd2);
        step();

        // Round-robin over four single-beat requesters
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", 32'(grant), 32'(k % NCH));
        end

        // Three-beat packet on channel 1 while 0 and 3 also request
        in_valid = 4'b1011;
        set_ch(0, 8'h01, 1'b1); set_ch(3, 8'h03, 1'b1);
        set_ch(1, 8'h11, 1'b0); step();
        check("lock_b1", 32'(out_data), 32'h11); check("lock_busy1", 32'(busy), 32'd1);
        set_ch(1, 8'h12, 1'b0); step();
        check("lock_b2", 32'(out_data), 32'h12); check("lock_busy2", 32'(busy), 32'd1);
        set_ch(1, 8'h13, 1'b1); step();
        check("lock_b3", 32'(out_data), 32'h13); check("lock_busy3", 32'(busy), 32'd0);
        step();
        check("lock_next", 32'(grant), 32'd3);

        // Backpressure holds the output register
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 8'h3C, 1'b1);
        step();
        set_ch(0, 8'h55, 1'b1); out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        step();
        check("bp_next", 32'(out_data), 32'h55);
        in_valid = '0;
        step();

        // Mode change while locked on channel 2
        mode = 1'b1; in_valid = 4'b0100; set_ch(2, 8'h21, 1'b0);
        step();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1111; in_last = 4'b1011;
        set_ch(2, 8'h22, 1'b0); step();
        check("mc_hold", 32'(grant), 32'd2);
        set_ch(2, 8'h23, 1'b1); step();
        check("mc_end", 32'(grant), 32'd2);
        step();
        check("mc_sel", 32'(grant), 32'd3);

        // Reset during a packet on channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'h31, 1'b0);
        step();
        set_ch(2, 8'h32, 1'b0); step();
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
        step();
        check("rst_first_grant", 32'(grant), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel       = SW'($urandom_range(0, NCH - 1));
            in_data   = {$urandom};
            in_valid  = NCH'($urandom);
            in_last   = NCH'($urandom & $urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
